// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result capture/display block.
// Holds the default history depth, the history entry layout, the octal
// seven-segment lookup table, the dash pattern and the digit-select enum.
package alu_disp_pkg;

    localparam int unsigned HIST_DEPTH_DEF = 4;

    typedef struct packed {
        logic [2:0] ctrl;
        logic [5:0] result;
    } entry_t;

    // Segment order {g,f,e,d,c,b,a}, active-high.
    localparam logic [6:0] SEG_LUT [8] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07
    };
    localparam logic [6:0] SEG_DASH = 7'h40;

    typedef enum logic [1:0] {
        DigLo = 2'd0,
        DigHi = 2'd1,
        DigOp = 2'd2
    } dig_sel_e;

    function automatic logic [6:0] seg_encode(input logic [2:0] val);
        return SEG_LUT[val];
    endfunction

endpackage

// File: rtl/alu_result_capture_if.sv
// Bus between the ALU side / panel and alu_result_capture.
//   result_i, ctrl_i        : ALU result and opcode
//   cap_btn_i, view_btn_i   : raw push buttons
//   seg_o, dig_o            : multiplexed seven-segment drive
//   hist_idx_o, empty_o     : history view index and empty flag
// master drives the inputs and observes the display; slave is the capture block.
interface alu_result_capture_if;

    logic [5:0] result_i;
    logic [2:0] ctrl_i;
    logic       cap_btn_i;
    logic       view_btn_i;
    logic [6:0] seg_o;
    logic [2:0] dig_o;
    logic [1:0] hist_idx_o;
    logic       empty_o;

    modport master (
        output result_i, ctrl_i, cap_btn_i, view_btn_i,
        input  seg_o, dig_o, hist_idx_o, empty_o
    );

    modport slave (
        input  result_i, ctrl_i, cap_btn_i, view_btn_i,
        output seg_o, dig_o, hist_idx_o, empty_o
    );

endinterface

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, debouncer and rising-edge pulse.
//   clk, rst_n : clock, synchronous active-low reset
//   btn        : raw asynchronous button level
//   pulse      : one-cycle pulse on each accepted press
// The debounced level flips only after DB_CYCLES consecutive synchronized
// samples that disagree with it; any agreeing sample restarts the count.
module btn_debounce #(
    parameter int unsigned DB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int unsigned CNT_W = $clog2(DB_CYCLES + 1);

    logic [1:0]       sync_q;
    logic [CNT_W-1:0] cnt_q;
    logic             db_q;
    logic             db_prev_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q    <= '0;
            cnt_q     <= '0;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn};
            db_prev_q <= db_q;
            if (sync_q[1] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DB_CYCLES - 1)) begin
                db_q  <= sync_q[1];
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pulse = db_q & ~db_prev_q;

endmodule

// File: rtl/alu_result_capture.sv
// Captures the ALU result (and opcode) on a debounced button press into a
// circular history and shows the selected entry on a multiplexed
// seven-segment display as two octal digits.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : alu_result_capture_if.slave (inputs, display, index, empty)
// Optional feature: define ALU_CAP_OPCODE_EN to store the opcode and scan a
// third digit showing it; otherwise dig_o[2] is tied low.
module alu_result_capture
    import alu_disp_pkg::*;
#(
    parameter int unsigned DB_CYCLES  = 16,
    parameter int unsigned REFRESH_W  = 10,
    parameter int unsigned HIST_DEPTH = HIST_DEPTH_DEF
) (
    input  logic                  clk,
    input  logic                  rst_n,
    alu_result_capture_if.slave   bus
);

    localparam int unsigned PTR_W = $clog2(HIST_DEPTH);
    localparam int unsigned CNT_W = $clog2(HIST_DEPTH + 1);
`ifdef ALU_CAP_OPCODE_EN
    localparam int unsigned NUM_DIG = 3;
`else
    localparam int unsigned NUM_DIG = 2;
`endif

    logic cap_p;
    logic view_p;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_cap_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.cap_btn_i),
        .pulse (cap_p)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_view_db (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (bus.view_btn_i),
        .pulse (view_p)
    );

`ifdef ALU_CAP_OPCODE_EN
    entry_t     hist_q [HIST_DEPTH];
`else
    logic [5:0] hist_q [HIST_DEPTH];
    logic       unused_ctrl;
    assign unused_ctrl = ^bus.ctrl_i;
`endif
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] view_q;
    logic [CNT_W-1:0] count_q;
    logic [PTR_W-1:0] sel_idx;
    logic [5:0]       sel_result;
    logic             empty;

    // Capture has priority over browse when both pulses coincide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            view_q   <= '0;
            count_q  <= '0;
        end else if (cap_p) begin
`ifdef ALU_CAP_OPCODE_EN
            hist_q[wr_ptr_q] <= '{ctrl: bus.ctrl_i, result: bus.result_i};
`else
            hist_q[wr_ptr_q] <= bus.result_i;
`endif
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            view_q   <= '0;
            if (count_q != CNT_W'(HIST_DEPTH)) begin
                count_q <= count_q + CNT_W'(1);
            end
        end else if (view_p && !empty) begin
            if (CNT_W'(view_q) == count_q - CNT_W'(1)) begin
                view_q <= '0;
            end else begin
                view_q <= view_q + PTR_W'(1);
            end
        end
    end

    assign empty   = (count_q == '0);
    // Newest entry sits just behind the write pointer.
    assign sel_idx = wr_ptr_q - PTR_W'(1) - view_q;
`ifdef ALU_CAP_OPCODE_EN
    logic [2:0] sel_ctrl;
    assign sel_result = hist_q[sel_idx].result;
    assign sel_ctrl   = hist_q[sel_idx].ctrl;
`else
    assign sel_result = hist_q[sel_idx];
`endif

    // Display scan
    logic [REFRESH_W-1:0] refresh_q;
    dig_sel_e             dig_sel_q;
    dig_sel_e             dig_sel_d;
    logic [NUM_DIG-1:0]   dig_q;
    logic [NUM_DIG-1:0]   dig_d;
    logic [6:0]           seg_q;
    logic [6:0]           seg_d;

    // Segment data is decoded for the digit about to be lit so that digit
    // enable and segments switch on the same edge.
    always_comb begin
        dig_sel_d = dig_sel_q;
        if (&refresh_q) begin
            unique case (dig_sel_q)
                DigLo:   dig_sel_d = DigHi;
`ifdef ALU_CAP_OPCODE_EN
                DigHi:   dig_sel_d = DigOp;
                DigOp:   dig_sel_d = DigLo;
`else
                DigHi:   dig_sel_d = DigLo;
`endif
                default: dig_sel_d = DigLo;
            endcase
        end

        dig_d = NUM_DIG'(1) << dig_sel_d;

        seg_d = SEG_DASH;
        if (!empty) begin
            case (dig_sel_d)
                DigLo:   seg_d = seg_encode(sel_result[2:0]);
                DigHi:   seg_d = seg_encode(sel_result[5:3]);
`ifdef ALU_CAP_OPCODE_EN
                DigOp:   seg_d = seg_encode(sel_ctrl);
`endif
                default: seg_d = SEG_DASH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            refresh_q <= '0;
            dig_sel_q <= DigLo;
            dig_q     <= NUM_DIG'(1);
            seg_q     <= SEG_DASH;
        end else begin
            refresh_q <= refresh_q + REFRESH_W'(1);
            dig_sel_q <= dig_sel_d;
            dig_q     <= dig_d;
            seg_q     <= seg_d;
        end
    end

`ifdef ALU_CAP_OPCODE_EN
    assign bus.dig_o = dig_q;
`else
    assign bus.dig_o = {1'b0, dig_q};
`endif
    assign bus.seg_o      = seg_q;
    assign bus.hist_idx_o = view_q;
    assign bus.empty_o    = empty;

endmodule

// File: tb/tb_alu_result_capture.sv
// Directed bench for alu_result_capture with default parameters.
module tb_alu_result_capture;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    alu_result_capture_if bus ();

    alu_result_capture dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Bounded wait for a given digit enable; a timeout shows up as a failed check.
    task automatic wait_dig(input logic [2:0] target);
        int n = 0;
        while (bus.dig_o !== target && n < 5000) begin
            tick(1);
            n++;
        end
        check("dig_wait", {13'd0, bus.dig_o}, {13'd0, target});
    endtask

    task automatic press_cap(input logic [5:0] r, input logic [2:0] c);
        bus.result_i  = r;
        bus.ctrl_i    = c;
        bus.cap_btn_i = 1'b1;
        tick(20);
        bus.cap_btn_i = 1'b0;
        bus.result_i  = ~r;
        bus.ctrl_i    = ~c;
        tick(20);
    endtask

    task automatic press_view();
        bus.view_btn_i = 1'b1;
        tick(20);
        bus.view_btn_i = 1'b0;
        tick(20);
    endtask

    task automatic check_digits(input string tag, input logic [6:0] hi, input logic [6:0] lo);
        wait_dig(3'b010);
        check({tag, "_hi"}, {9'd0, bus.seg_o}, {9'd0, hi});
        wait_dig(3'b001);
        check({tag, "_lo"}, {9'd0, bus.seg_o}, {9'd0, lo});
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.result_i   = '0;
        bus.ctrl_i     = '0;
        bus.cap_btn_i  = 1'b0;
        bus.view_btn_i = 1'b0;
        tick(3);
        rst_n = 1'b1;

        // Reset state
        check("rst_seg", {9'd0, bus.seg_o}, 16'h40);
        check("rst_dig", {13'd0, bus.dig_o}, 16'h1);
        check("rst_idx", {14'd0, bus.hist_idx_o}, 16'h0);
        check("rst_empty", {15'd0, bus.empty_o}, 16'h1);

        // Idle scan: digit advances after 1024 cycles
        tick(1023);
        check("scan_hold", {13'd0, bus.dig_o}, 16'h1);
        tick(1);
        check("scan_d1", {13'd0, bus.dig_o}, 16'h2);
        check("scan_d1_seg", {9'd0, bus.seg_o}, 16'h40);
        tick(1024);
        check("scan_d0", {13'd0, bus.dig_o}, 16'h1);
        check("scan_d0_seg", {9'd0, bus.seg_o}, 16'h40);

        // First capture: pulse lands 18 edges after press, captured on edge 19
        bus.result_i  = 6'o53;
        bus.ctrl_i    = 3'd2;
        bus.cap_btn_i = 1'b1;
        tick(18);
        check("cap_early", {15'd0, bus.empty_o}, 16'h1);
        tick(1);
        check("cap_edge", {15'd0, bus.empty_o}, 16'h0);
        tick(21);
        bus.cap_btn_i = 1'b0;
        bus.result_i  = 6'o77;
        tick(20);
        check_digits("cap53", 7'h6D, 7'h4F);

        // Short bounces must not capture
        bus.result_i  = 6'o11;
        bus.cap_btn_i = 1'b1;
        tick(10);
        bus.cap_btn_i = 1'b0;
        tick(5);
        bus.cap_btn_i = 1'b1;
        tick(10);
        bus.cap_btn_i = 1'b0;
        tick(40);
        check_digits("bounce", 7'h6D, 7'h4F);

        // Fresh history with five captures; oldest is overwritten
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        check("rst2_empty", {15'd0, bus.empty_o}, 16'h1);
        for (int v = 1; v <= 5; v++) begin
            press_cap(6'(v), 3'd0);
        end
        check("five_idx", {14'd0, bus.hist_idx_o}, 16'h0);
        check_digits("newest", 7'h3F, 7'h6D);
        press_view();
        check("view1_idx", {14'd0, bus.hist_idx_o}, 16'h1);
        check_digits("view1", 7'h3F, 7'h66);
        press_view();
        check("view2_idx", {14'd0, bus.hist_idx_o}, 16'h2);
        check_digits("view2", 7'h3F, 7'h4F);
        press_view();
        check("view3_idx", {14'd0, bus.hist_idx_o}, 16'h3);
        check_digits("view3", 7'h3F, 7'h5B);
        press_view();
        check("view_wrap_idx", {14'd0, bus.hist_idx_o}, 16'h0);
        check_digits("view_wrap", 7'h3F, 7'h6D);

        // Simultaneous press: capture wins, index returns to 0
        press_view();
        check("pre_sim_idx", {14'd0, bus.hist_idx_o}, 16'h1);
        bus.result_i   = 6'o66;
        bus.cap_btn_i  = 1'b1;
        bus.view_btn_i = 1'b1;
        tick(20);
        bus.cap_btn_i  = 1'b0;
        bus.view_btn_i = 1'b0;
        bus.result_i   = 6'o00;
        tick(20);
        check("sim_idx", {14'd0, bus.hist_idx_o}, 16'h0);
        check_digits("sim", 7'h7D, 7'h7D);

`ifdef ALU_CAP_OPCODE_EN
        press_cap(6'o12, 3'd6);
        wait_dig(3'b100);
        check("op_seg", {9'd0, bus.seg_o}, 16'h7D);
`else
        wait_dig(3'b010);
        check("no_op_dig2", {15'd0, bus.dig_o[2]}, 16'h0);
`endif
        // Reset mid-scan
        tick(100);
        rst_n = 1'b0;
        tick(1);
        check("mid_rst_seg", {9'd0, bus.seg_o}, 16'h40);
        check("mid_rst_dig", {13'd0, bus.dig_o}, 16'h1);
        check("mid_rst_empty", {15'd0, bus.empty_o}, 16'h1);
        check("mid_rst_idx", {14'd0, bus.hist_idx_o}, 16'h0);
        rst_n = 1'b1;
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_capture.md
# alu_result_capture

Downstream consumer of the 3-bit ALU's 6-bit result. It captures the result, together with the opcode that produced it, on a debounced push-button. It holds the last four captures in a circular history and drives a time-multiplexed seven-segment display showing the selected result as two octal digits. It gives the ALU a human-readable, latched output in place of raw LEDs.

## Interface
Parameters:
- DB_CYCLES, 16: consecutive stable cycles required before a button level is accepted.
- REFRESH_W, 10: width of the digit-multiplex counter; each digit is lit for 2^REFRESH_W cycles.
- HIST_DEPTH, 4: history entries; fixed to a power of two, minimum 2.

Ports:
- clk, in, 1: system clock.
- rst_n, in, 1: reset, synchronous, active-low. One clock; all state is reset synchronously on the clock edge while rst_n=0.
- result_i, in, 6: ALU result.
- ctrl_i, in, 3: ALU opcode, captured alongside result_i.
- cap_btn_i, in, 1: raw, asynchronous capture button, active-high.
- view_btn_i, in, 1: raw, asynchronous browse button, active-high.
- seg_o, out, 7: segments {g,f,e,d,c,b,a}, active-high.
- dig_o, out, 3: one-hot digit enable.
- hist_idx_o, out, 2: current view index; 0 is the newest entry.
- empty_o, out, 1: high while the history holds no entries.

## Operation
- Button input path:
  - Each button passes through a 2-flop synchronizer, then a debouncer.
  - The debounced level changes only after DB_CYCLES consecutive identical synchronized samples.
  - A rising edge of the debounced level produces a 1-cycle pulse (cap_p, view_p).
- Capture:
  - On cap_p, {ctrl_i, result_i} is written at the write pointer, the pointer increments mod HIST_DEPTH, and count increments, saturating at HIST_DEPTH.
  - When full, the oldest entry is overwritten.
  - view index resets to 0.
- Browse:
  - On view_p with count>0, the view index increments.
  - The index wraps to 0 after count-1.
  - With count=0, view_p is ignored.
- Simultaneous cap_p and view_p in the same cycle: capture wins and view_p is dropped.
- Selected entry = history[(wr_ptr - 1 - view) mod HIST_DEPTH].
- Display:
  - Digit 0 shows result[2:0] and digit 1 shows result[5:3], both in octal 0–7.
  - Digits scan 0→1→0, advancing on counter wrap.
- Empty history: every lit digit shows a dash (0x40).
- Segment codes: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07.
- Reset values:
  - seg_o=0x40
  - dig_o=3'b001
  - hist_idx_o=0
  - empty_o=1
  - count=0, wr_ptr=0, refresh counter=0
  - Debounced levels are 0, so a button held through reset generates a pulse only once it has been seen stable-high for DB_CYCLES cycles after reset.
- Reset asserted mid-debounce or mid-scan discards all history and in-flight state.

## Timing
- Button edge to pulse: 2 synchronizer cycles plus DB_CYCLES cycles.
- Storage, count, view and empty_o update on the clock edge that samples the pulse.
- seg_o and dig_o are registered and reflect new storage one cycle later.
- Sampling of result_i and ctrl_i:
  - Both are sampled in the pulse cycle only.
  - The ALU is combinational, so no handshake is needed.
  - Changes on these inputs outside the pulse cycle have no effect.
- dig_o and seg_o always change on the same edge, so there is no ghosting cycle.

## Configuration
- ALU_CAP_OPCODE_EN defined:
  - The scan covers three digits, 0→1→2→0.
  - Digit 2 shows the stored ctrl as 0–7, or a dash when empty.
- ALU_CAP_OPCODE_EN undefined:
  - ctrl is not stored.
  - dig_o[2] is tied to 0 and the scan covers two digits.

## Structure
- Package alu_disp_pkg holds:
  - HIST_DEPTH default.
  - Entry typedef {ctrl[2:0], result[5:0]}.
  - Seven-segment constant array and SEG_DASH.
  - Digit-select enum.
- Sub-module btn_debounce: synchronizer, DB_CYCLES counter and rising-edge pulse. It is instantiated twice, once per button.

## Test plan
- Reset, then idle 5000 cycles → seg_o=0x40, empty_o=1, dig_o alternates 001/010 every 1024 cycles.
- result_i=6'o53, press cap_btn for 40 cycles → after 19 cycles empty_o=0; digit 1 seg=0x6D, digit 0 seg=0x4F.
- Bounce cap_btn 1-0-1 with pulses shorter than 16 cycles → no capture, count unchanged.
- Capture 5 values 0o01…0o05, then press view 3 times → hist_idx_o 1,2,3 showing 0o04, 0o03, 0o02; a 4th press wraps to 0 showing 0o05; 0o01 is never shown.
- Pulses on both buttons in the same cycle → entry stored, hist_idx_o=0.
- With ALU_CAP_OPCODE_EN, ctrl_i=3'd6 captured → dig_o=100 shows 0x7D; assert rst_n=0 mid-scan → next edge seg_o=0x40, dig_o=001.
